rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter with grant hold and bounded tenure. It shares one resource between eight requesters and tracks the winner as a 3-bit index. The one-hot grant vector comes from a 3-to-8 decoder with enable, so the rest of the design sees the same one-hot select style as the decoder datapath. It sits between requesting agents and the shared one-hot-selected resource.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/onehot_dec3.sv | 19 +
 rtl/rr_arbiter8.sv | 91 +++++++++
 tb/tb_rr_arbiter8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the round-robin selection helper for the 8-way arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_sel_t;

  // First set bit of v scanning ptr, ptr+1, ... with modulo-8 wrap.
  // Walking the offsets downward lets the lowest offset win the last write.
  function automatic rr_sel_t next_rr(input logic [N_REQ-1:0] v,
                                      input logic [IDX_W-1:0] ptr);
    rr_sel_t          s;
    logic [IDX_W-1:0] j;
    s = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      j = ptr + IDX_W'(i);
      if (v[j]) begin
        s.found = 1'b1;
        s.idx   = j;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable, built from two enabled 2-to-4 stages.
module onehot_dec3 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] y
);

  logic [1:0] stg_en;

  // idx[2] picks which 2-to-4 stage is live.
  assign stg_en = {en & idx[2], en & ~idx[2]};

  for (genvar s = 0; s < 2; s++) begin : g_stg
    for (genvar k = 0; k < 4; k++) begin : g_out
      assign y[s*4+k] = stg_en[s] & (idx[1:0] == 2'(k));
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold and bounded tenure.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int            CW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic [N_REQ-1:0] req_msk;
  rr_sel_t          sel_all, sel_msk;

  assign req_msk = req & ~(N_REQ'(1) << idx);
  assign sel_all = next_rr(req, ptr);
  assign sel_msk = next_rr(req_msk, ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (en && sel_all.found) begin
          state_nxt = GRANT;
          idx_nxt   = sel_all.idx;
          ptr_nxt   = sel_all.idx + 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (!req[idx] || cnt == CNT_MAX) begin
          // Release and expiry share the masked pick; they differ only
          // when nobody else is waiting.
          if (sel_msk.found) begin
            idx_nxt = sel_msk.idx;
            ptr_nxt = sel_msk.idx + 1'b1;
            cnt_nxt = '0;
          end else if (!req[idx]) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);
  assign gnt_idx   = idx;

  onehot_dec3 u_dec (
    .idx (idx),
    .en  (gnt_valid),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed + randomized bench for rr_arbiter8 against a tenure/priority model.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       en;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks   = 0;
  int failures = 0;

  // Model: current holder (-1 none), last winner, next priority, cycles held.
  int m_hold, m_last, m_prio, m_held;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_hold = -1; m_last = 0; m_prio = 0; m_held = 0;
  endtask

  function automatic int pick(input logic [7:0] v, input int excl);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (m_prio + k) % 8;
      if (v[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_hold = w; m_last = w; m_prio = (w + 1) % 8; m_held = 1;
  endtask

  task automatic m_step();
    int w;
    if (m_hold < 0) begin
      w = pick(req, -1);
      if (en && w >= 0) m_grant(w);
    end else if (!en) begin
      m_hold = -1;
    end else if (!req[m_hold]) begin
      w = pick(req, m_hold);
      if (w >= 0) m_grant(w);
      else m_hold = -1;
    end else if (m_held == MAXH) begin
      w = pick(req, m_hold);
      if (w >= 0) m_grant(w);
      else m_held = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    eg = (m_hold >= 0) ? 8'(1 << m_hold) : 8'h00;
    checks++;
    assert (gnt === eg) else begin
      failures++;
      $error("FAIL %s gnt got=%h exp=%h", tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === (m_hold >= 0)) else begin
      failures++;
      $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, (m_hold >= 0));
    end
    checks++;
    assert (gnt_idx === 3'(m_last)) else begin
      failures++;
      $error("FAIL %s gnt_idx got=%0d exp=%0d", tag, gnt_idx, m_last);
    end
  endtask

  task automatic check_gnt(input string tag, input logic [7:0] exp);
    checks++;
    assert (gnt === exp) else begin
      failures++;
      $error("FAIL %s gnt got=%h exp=%h", tag, gnt, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) m_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0; req = 8'hFF; en = 1'b1;
    repeat (2) tick("reset_hold");

    rst_n = 1'b1; req = 8'h00;
    repeat (2) tick("reset_release");

    // Single requester 4, then release.
    req = 8'h10;
    tick("single_grant");
    check_gnt("single_grant_const", 8'h10);
    req = 8'h00;
    tick("single_drop");
    check_gnt("single_drop_const", 8'h00);

    // ptr sits at 5: requesters 5 and 0 alternate every MAXH cycles.
    req = 8'h21;
    tick("rot_first");
    check_gnt("rot_first_const", 8'h20);
    repeat (MAXH) tick("rot");
    check_gnt("rot_swap_const", 8'h01);
    repeat (3*MAXH) tick("rot");

    // Lone holder keeps the grant across expiry.
    req = 8'h01;
    repeat (40) tick("lone");
    check_gnt("lone_const", 8'h01);

    // Zero-bubble handover 0 -> 2 -> 3.
    req = 8'h0C;
    tick("zb_to2");
    check_gnt("zb_to2_const", 8'h04);
    req = 8'h08;
    tick("zb_to3");
    check_gnt("zb_to3_const", 8'h08);

    // en drop and resume from kept pointer.
    en = 1'b0;
    tick("en_drop");
    check_gnt("en_drop_const", 8'h00);
    en = 1'b1; req = 8'hFF;
    tick("en_resume");
    check_gnt("en_resume_const", 8'h10);

    // Asynchronous reset mid-grant clears immediately.
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    tick("async_rst_hold");
    rst_n = 1'b1; req = 8'hFF;
    tick("post_rst");
    check_gnt("post_rst_ptr0", 8'h01);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom);
        2: req = 8'($urandom) & 8'($urandom) & 8'($urandom);
        default: ;
      endcase
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("rand_async_rst");
        tick("rand_rst_hold");
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
